// File: rtl/spork_alu.sv
// spork_alu: registered 16-bit add/sub/and/xor ALU with zero and operand-equality flags
package spork_pkg;
    typedef enum logic [1:0] {
        k_add = 2'b00,
        k_sub = 2'b01,
        k_and = 2'b10,
        k_xor = 2'b11
    } op_t;
endpackage

module spork_alu
    import spork_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  op_t              op,
    input  logic [WIDTH-1:0] inputa,
    input  logic [WIDTH-1:0] inputb,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             equal
);
    logic [WIDTH-1:0] res;
    always_comb begin
        res = op == k_add ? inputa + inputb :
              op == k_sub ? inputa - inputb :
              op == k_and ? inputa & inputb :
                            inputa ^ inputb;
    end
    // zero comes from the result being captured, not from the stale out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out   <= '0;
            zero  <= 1'b1;
            equal <= 1'b0;
        end else begin
            out   <= res;
            zero  <= res == '0;
            equal <= inputa == inputb;
        end
    end
    a_op_known: assert property (@(posedge clk) disable iff (!rst_n) !$isunknown(op))
        else $error("spork_alu: op is X/Z");
endmodule

// File: tb/tb_spork_alu.sv
// tb_spork_alu: directed table, reset corners and randomized model check for spork_alu
module tb_spork_alu;
    import spork_pkg::*;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    op_t         op = k_add;
    logic [15:0] ina = 16'h1234, inb = 16'h00ff;
    logic [15:0] out;
    logic        zero, equal;
    logic [15:0] exp_o = 16'h0;
    logic        exp_z = 1'b1, exp_e = 1'b0;
    int          n_vec = 0, n_bad = 0;

    spork_alu #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .inputa(ina), .inputb(inb),
        .out(out), .zero(zero), .equal(equal)
    );

    always #5 clk = ~clk;

    typedef struct {
        op_t         op;
        logic [15:0] a, b, o;
        logic        z, e;
    } vec_t;

    function automatic logic [15:0] ref_alu(input op_t o, input logic [15:0] a, b);
        int ia = int'(a), ib = int'(b);
        case (o)
            k_add:   return 16'((ia + ib) % 65536);
            k_sub:   return 16'((ia - ib + 65536) % 65536);
            k_and:   return a & b;
            default: return a ^ b;
        endcase
    endfunction

    task automatic chk(input string name, input logic [15:0] got, want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (op=%0d a=%h b=%h t=%0t)",
                     name, got, want, op, ina, inb, $time);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, "_out"}, out, exp_o);
        chk({tag, "_zero"}, {15'b0, zero}, {15'b0, exp_z});
        chk({tag, "_equal"}, {15'b0, equal}, {15'b0, exp_e});
    endtask

    // new inputs land at negedge; outputs must not move until the next posedge
    task automatic apply(input op_t o, input logic [15:0] a, b, eo, input logic ez, ee);
        @(negedge clk);
        op = o; ina = a; inb = b;
        #1 chk_all("hold");
        @(posedge clk);
        #1;
        exp_o = eo; exp_z = ez; exp_e = ee;
        chk_all("result");
    endtask

    task automatic apply_rand(input op_t o, input logic [15:0] a, b);
        logic [15:0] r;
        r = ref_alu(o, a, b);
        apply(o, a, b, r, r == 16'h0, a == b);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        exp_o = 16'h0; exp_z = 1'b1; exp_e = 1'b0;
        #1 chk_all("rst_async");
        @(posedge clk);
        #1 chk_all("rst_held");
        rst_n = 1'b1;
    endtask

    vec_t tbl[$];

    initial begin
        tbl.push_back('{k_add, 16'h0004, 16'h0004, 16'h0008, 1'b0, 1'b1});
        tbl.push_back('{k_sub, 16'h0004, 16'h0004, 16'h0000, 1'b1, 1'b1});
        tbl.push_back('{k_and, 16'h0004, 16'h0004, 16'h0004, 1'b0, 1'b1});
        tbl.push_back('{k_xor, 16'h0004, 16'h0003, 16'h0007, 1'b0, 1'b0});
        tbl.push_back('{k_and, 16'h0004, 16'h0003, 16'h0000, 1'b1, 1'b0});
        tbl.push_back('{k_add, 16'hffff, 16'h0001, 16'h0000, 1'b1, 1'b0});
        tbl.push_back('{k_sub, 16'h0000, 16'h0001, 16'hffff, 1'b0, 1'b0});
        tbl.push_back('{k_xor, 16'ha5a5, 16'ha5a5, 16'h0000, 1'b1, 1'b1});

        // asynchronous reset with nonzero inputs, before any clock edge
        #1 rst_n = 1'b0;
        #1 chk_all("rst_noclk");
        @(posedge clk);
        #1 chk_all("rst_noclk_held");
        #1 rst_n = 1'b1;

        // back-to-back table: op changes every cycle, no bubbles
        foreach (tbl[i]) apply(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].o, tbl[i].z, tbl[i].e);

        // mid-stream reset discards the pending result, then stream resumes
        apply_rand(k_add, 16'h1111, 16'h2222);
        pulse_reset();
        apply_rand(k_sub, 16'h0005, 16'h0007);

        for (int i = 0; i < 10000; i++) begin
            logic [15:0] a, b;
            a = 16'($urandom);
            b = $urandom_range(7) == 0 ? a : 16'($urandom);
            if ($urandom_range(3) == 0) a = 16'($urandom_range(3));
            if ($urandom_range(199) == 0) pulse_reset();
            apply_rand(op_t'($urandom_range(3)), a, b);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
